// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: default character width and pointer-width helper.
package uart_rx_fifo_pkg;

  // Character width shared by the receiver, transmitter and buffers.
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Pointer width for a power-of-two FIFO: index bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : uart_rx_fifo_pkg

// File: rtl/uart_rx_fifo_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count one per pulse, stick at all-ones, clear on reset or clr.
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : sat_counter

// File: rtl/uart_rx_fifo.sv
// Receive-side elastic buffer: FWFT power-of-two FIFO between the UART
// receiver and its consumer, plus saturating overrun/frame error statistics.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  input  logic                       overrun_error,
  input  logic                       frame_error,
  input  logic                       clr_stats,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_WIDTH-1:0]       overrun_count,
  output logic [CNT_WIDTH-1:0]       frame_count
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int IDX_W = PTR_W - 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;

  // Status decode straight from the pointer registers.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                 (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

  // Ready depends only on fullness, never on a same-cycle pop.
  assign s_axis_tready = ~full;
  assign m_axis_tvalid = ~empty;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;

  // Modulo subtraction of the wrap-extended pointers gives 0..DEPTH.
  assign level = wr_ptr - rd_ptr;

  // First-word-fall-through: head character read combinationally.
  assign m_axis_tdata = mem[rd_ptr[IDX_W-1:0]];

  // Pointer update; reset empties the FIFO at once, wrap is natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Character storage written at the write index on every push.
  // NOTE: the memory has no reset; stale entries are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= s_axis_tdata;
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_overrun_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_stats),
    .inc   (overrun_error),
    .count (overrun_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_stats),
    .inc   (frame_error),
    .count (frame_count)
  );

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios then random
// traffic, all compared against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [DW-1:0]    s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             overrun_error;
  logic             frame_error;
  logic             clr_stats;
  logic [$clog2(DEPTH):0] level;
  logic [CW-1:0]    overrun_count;
  logic [CW-1:0]    frame_count;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .overrun_error (overrun_error),
    .frame_error   (frame_error),
    .clr_stats     (clr_stats),
    .level         (level),
    .overrun_count (overrun_count),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the FIFO is a plain queue, the counters plain integers.
  byte unsigned q[$];
  int ov_m = 0;
  int fr_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every observable output against the model.
  task automatic check_all(input string where);
    check({where, ".level"},  32'(level),         32'(q.size()));
    check({where, ".mvalid"}, 32'(m_axis_tvalid), 32'(q.size() != 0));
    check({where, ".sready"}, 32'(s_axis_tready), 32'(q.size() < DEPTH));
    check({where, ".ovcnt"},  32'(overrun_count), 32'(ov_m));
    check({where, ".frcnt"},  32'(frame_count),   32'(fr_m));
    if (q.size() != 0) check({where, ".head"}, 32'(m_axis_tdata), 32'(q[0]));
  endtask

  // Apply the current inputs for one clock edge, advance the model, then check.
  task automatic step(input string where);
    bit do_push, do_pop;
    if (reset) begin
      q.delete();
      ov_m = 0;
      fr_m = 0;
    end else begin
      do_push = s_axis_tvalid && (q.size() < DEPTH);
      do_pop  = m_axis_tready && (q.size() > 0);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(s_axis_tdata);
      if (clr_stats) begin
        ov_m = 0;
        fr_m = 0;
      end else begin
        if (overrun_error) ov_m = (ov_m < CMAX) ? ov_m + 1 : CMAX;
        if (frame_error)   fr_m = (fr_m < CMAX) ? fr_m + 1 : CMAX;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all(where);
  endtask

  initial begin
    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    overrun_error = 1'b0;
    frame_error   = 1'b0;
    clr_stats     = 1'b0;
    @(negedge clk);
    step("rst0");
    step("rst1");
    reset = 1'b0;
    check("rst.level", 32'(level), 32'd0);
    check("rst.sready", 32'(s_axis_tready), 32'd1);

    // Three characters pushed with the consumer stalled, then drained in order.
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 8'h41; step("t1.p0");
    s_axis_tdata = 8'h42; step("t1.p1");
    s_axis_tdata = 8'h43; step("t1.p2");
    s_axis_tvalid = 1'b0;
    check("t1.level3", 32'(level), 32'd3);
    check("t1.head41", 32'(m_axis_tdata), 32'h41);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t1.popdata", 32'(m_axis_tdata), 32'h41 + 32'(i));
      step("t1.pop");
    end
    m_axis_tready = 1'b0;
    check("t1.empty", 32'(m_axis_tvalid), 32'd0);

    // Fill to full, hold a 17th character, free one slot, then drain.
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      s_axis_tdata = 8'(i);
      step("t2.fill");
    end
    check("t2.level16", 32'(level), 32'd16);
    check("t2.full", 32'(s_axis_tready), 32'd0);
    s_axis_tdata = 8'hAA;
    step("t2.hold0");
    step("t2.hold1");
    m_axis_tready = 1'b1;
    step("t2.pop1");
    m_axis_tready = 1'b0;
    check("t2.readyback", 32'(s_axis_tready), 32'd1);
    step("t2.acceptAA");
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      check("t2.drain", 32'(m_axis_tdata), 32'(i));
      step("t2.drain");
    end
    check("t2.AAlast", 32'(m_axis_tdata), 32'hAA);
    step("t2.popAA");
    m_axis_tready = 1'b0;

    // Hold level at 5 with concurrent push/pop across the pointer wrap.
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_axis_tdata = 8'(8'h80 + i);
      step("t3.pre");
    end
    m_axis_tready = 1'b1;
    for (int i = 5; i < 45; i++) begin
      s_axis_tdata = 8'(8'h80 + i);
      check("t3.order", 32'(m_axis_tdata), 32'(8'(8'h80 + i - 5)));
      step("t3.stream");
      check("t3.level5", 32'(level), 32'd5);
    end
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) step("t3.drain");
    m_axis_tready = 1'b0;

    // Error pulses, one frame pulse coincident with an overrun pulse.
    overrun_error = 1'b1; step("t4.ov1");
    frame_error   = 1'b1; step("t4.ov2fr1");
    frame_error   = 1'b0; step("t4.ov3");
    overrun_error = 1'b0;
    frame_error   = 1'b1; step("t4.fr2");
    frame_error   = 1'b0;
    check("t4.ov3", 32'(overrun_count), 32'd3);
    check("t4.fr2", 32'(frame_count), 32'd2);
    clr_stats = 1'b1; frame_error = 1'b1; step("t4.clr");
    clr_stats = 1'b0; frame_error = 1'b0;
    check("t4.clrov", 32'(overrun_count), 32'd0);
    check("t4.clrfr", 32'(frame_count), 32'd0);

    // Saturation of the 4-bit frame counter.
    frame_error = 1'b1;
    for (int i = 0; i < 20; i++) step("t5.sat");
    frame_error = 1'b0;
    step("t5.hold");
    check("t5.fr15", 32'(frame_count), 32'd15);

    // Reset in the middle of stored traffic.
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s_axis_tdata = 8'($urandom_range(255));
      step("t6.fill");
    end
    s_axis_tvalid = 1'b0;
    check("t6.level7", 32'(level), 32'd7);
    reset = 1'b1; step("t6.reset");
    reset = 1'b0;
    check("t6.level0", 32'(level), 32'd0);
    check("t6.mvalid0", 32'(m_axis_tvalid), 32'd0);
    check("t6.sready1", 32'(s_axis_tready), 32'd1);
    check("t6.fr0", 32'(frame_count), 32'd0);
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h55; step("t6.push55");
    s_axis_tvalid = 1'b0;
    check("t6.head55", 32'(m_axis_tdata), 32'h55);

    // Random traffic, error pulses, clears and occasional resets.
    for (int i = 0; i < 600; i++) begin
      s_axis_tvalid = ($urandom_range(99) < 60);
      m_axis_tready = ($urandom_range(99) < 50);
      s_axis_tdata  = 8'($urandom_range(255));
      overrun_error = ($urandom_range(99) < 15);
      frame_error   = ($urandom_range(99) < 15);
      clr_stats     = ($urandom_range(99) < 3);
      reset         = ($urandom_range(299) == 0);
      step("rnd");
    end
    reset = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    overrun_error = 1'b0; frame_error = 1'b0; clr_stats = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_fifo
